// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback port arbiter with in-order long-latency FIFO and WAW kill; optional WB_BYPASS_EN adds bypass lookup
module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_valid,
    input  logic [4:0]                  alu_reg,
    input  logic [DATA_W-1:0]           alu_data,
    input  logic                        lu_valid,
    input  logic [4:0]                  lu_reg,
    input  logic [DATA_W-1:0]           lu_data,
    output logic                        lu_ready,
    output logic [4:0]                  write_reg,
    output logic [DATA_W-1:0]           write_data,
    output logic                        regWrite,
    output logic [31:0]                 pending,
    output logic [$clog2(DEPTH):0]      fifo_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]                  byp_reg,
    output logic                        byp_hit,
    output logic [DATA_W-1:0]           byp_data
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [4:0]        ent_reg_q  [DEPTH];
    logic [4:0]        ent_reg_d  [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];
    logic [DEPTH-1:0]  live_q, live_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              reg_write_q, reg_write_d;
    logic [4:0]        write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              alu_w, lu_xfer, empty, pop, pass, push, head_live;
    assign lu_ready   = rst_n && (count_q < CW'(DEPTH));
    assign lu_xfer    = lu_valid && lu_ready;
    assign alu_w      = alu_valid && (alu_reg != 5'd0);
    assign empty      = (count_q == '0);
    assign pop        = !alu_w && !empty;
    assign pass       = !alu_w && empty && lu_xfer && (lu_reg != 5'd0);
    assign push       = lu_xfer && (lu_reg != 5'd0) && !pass;
    assign head_live  = pop && live_q[rd_ptr_q];
    assign regWrite   = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign fifo_count = count_q;
    always_comb begin
        ent_reg_d  = ent_reg_q;
        ent_data_d = ent_data_q;
        for (int i = 0; i < DEPTH; i++)
            live_d[i] = live_q[i] && !(alu_w && (ent_reg_q[i] == alu_reg));
        if (pop)
            live_d[rd_ptr_q] = 1'b0;
        if (push) begin
            live_d[wr_ptr_q]     = 1'b1;
            ent_reg_d[wr_ptr_q]  = lu_reg;
            ent_data_d[wr_ptr_q] = lu_data;
        end
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        wr_ptr_d     = wr_ptr_q + PW'(push);
        count_d      = count_q + CW'(push) - CW'(pop);
        reg_write_d  = alu_w || pass || head_live;
        write_reg_d  = alu_w ? alu_reg : head_live ? ent_reg_q[rd_ptr_q] : pass ? lu_reg : write_reg_q;
        write_data_d = alu_w ? alu_data : head_live ? ent_data_q[rd_ptr_q] : pass ? lu_data : write_data_q;
    end
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (live_q[i])
                pending[ent_reg_q[i]] = 1'b1;
        pending[0] = 1'b0;
    end
`ifdef WB_BYPASS_EN
    always_comb begin
        byp_hit  = reg_write_q && (write_reg_q == byp_reg);
        byp_data = byp_hit ? write_data_q : '0;
        for (int k = 0; k < DEPTH; k++)
            if (live_q[rd_ptr_q + PW'(k)] && (ent_reg_q[rd_ptr_q + PW'(k)] == byp_reg)) begin
                byp_hit  = 1'b1;
                byp_data = ent_data_q[rd_ptr_q + PW'(k)];
            end
        if (byp_reg == 5'd0) begin
            byp_hit  = 1'b0;
            byp_data = '0;
        end
    end
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
            live_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            ent_reg_q    <= ent_reg_d;
            ent_data_q   <= ent_data_d;
            live_q       <= live_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random stimulus checked against a queue-based writeback model
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        rst_n, alu_valid, lu_valid, lu_ready, regWrite;
    logic [4:0]  alu_reg, lu_reg, write_reg;
    logic [31:0] alu_data, lu_data, write_data, pending;
    logic [2:0]  fifo_count;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_reg;
    logic        byp_hit;
    logic [31:0] byp_data;
`endif
    always #5 clk = ~clk;
    wb_arbiter #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data), .lu_ready(lu_ready),
        .write_reg(write_reg), .write_data(write_data), .regWrite(regWrite),
        .pending(pending), .fifo_count(fifo_count)
`ifdef WB_BYPASS_EN
        , .byp_reg(byp_reg), .byp_hit(byp_hit), .byp_data(byp_data)
`endif
    );
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          live;
    } ent_t;
    ent_t        q[$];
    logic        m_rw = 1'b0;
    logic [4:0]  m_wr = '0;
    logic [31:0] m_wd = '0;
    int checks = 0;
    int errors = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] exp_pending();
        logic [31:0] p = '0;
        foreach (q[i])
            if (q[i].live && q[i].r != 5'd0)
                p = p | (32'd1 << q[i].r);
        return p;
    endfunction
    task automatic model_edge();
        bit   rdy, xfer, passed;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_rw = 1'b0;
            m_wr = '0;
            m_wd = '0;
            return;
        end
        rdy    = q.size() < DEPTH;
        xfer   = lu_valid && rdy;
        passed = 0;
        if (alu_valid && alu_reg != 5'd0) begin
            foreach (q[i])
                if (q[i].r == alu_reg)
                    q[i].live = 0;
            m_rw = 1'b1;
            m_wr = alu_reg;
            m_wd = alu_data;
        end else if (q.size() != 0) begin
            e    = q.pop_front();
            m_rw = e.live;
            if (e.live) begin
                m_wr = e.r;
                m_wd = e.d;
            end
        end else if (xfer && lu_reg != 5'd0) begin
            m_rw   = 1'b1;
            m_wr   = lu_reg;
            m_wd   = lu_data;
            passed = 1;
        end else
            m_rw = 1'b0;
        if (xfer && lu_reg != 5'd0 && !passed)
            q.push_back('{r: lu_reg, d: lu_data, live: 1});
    endtask
    task automatic step(input logic r, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ld);
`ifdef WB_BYPASS_EN
        bit          eh;
        logic [31:0] ed;
`endif
        rst_n = r; alu_valid = av; alu_reg = ar; alu_data = ad;
        lu_valid = lv; lu_reg = lr; lu_data = ld;
`ifdef WB_BYPASS_EN
        byp_reg = 5'($urandom_range(0, 7));
`endif
        #1;
        check("lu_ready", lu_ready, r && (q.size() < DEPTH));
`ifdef WB_BYPASS_EN
        eh = m_rw && (m_wr == byp_reg);
        ed = m_wd;
        for (int i = q.size() - 1; i >= 0; i--)
            if (!eh || ed !== m_wd || 1) begin
                if (q[i].live && q[i].r == byp_reg) begin
                    eh = 1;
                    ed = q[i].d;
                    break;
                end
            end
        if (byp_reg == 5'd0)
            eh = 0;
        check("byp_hit", byp_hit, eh);
        if (eh)
            check("byp_data", byp_data, ed);
`endif
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("regWrite", regWrite, m_rw);
        if (m_rw || !r) begin
            check("write_reg", write_reg, m_wr);
            check("write_data", write_data, m_wd);
        end
        check("pending", pending, exp_pending());
        check("fifo_count", fifo_count, q.size());
    endtask
    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        rst_n = 0; alu_valid = 0; alu_reg = 0; alu_data = 0;
        lu_valid = 0; lu_reg = 0; lu_data = 0;
`ifdef WB_BYPASS_EN
        byp_reg = 0;
`endif
        @(negedge clk);
        step(0, 0, 0, 0, 1, 5, 32'h55);
        step(0, 0, 0, 0, 1, 5, 32'h55);
        idle();
        step(1, 0, 0, 0, 1, 5, 32'h11);
        idle();
        step(1, 1, 3, 32'hA, 1, 4, 32'hB);
        idle();
        idle();
        for (int i = 0; i < 5; i++)
            step(1, 1, 1, 32'(i), 1, 5'(8 + i), 32'h100 + 32'(i));
        for (int i = 0; i < 6; i++)
            idle();
        step(1, 1, 2, 32'h1, 1, 7, 32'h70);
        step(1, 1, 7, 32'h99, 0, 0, 0);
        idle();
        step(1, 1, 0, 32'h5, 1, 0, 32'h6);
        idle();
        for (int i = 0; i < 3000; i++) begin
            int ap = (i / 250) % 3 == 0 ? 90 : (i / 250) % 3 == 1 ? 50 : 15;
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 99) < ap, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter driving the single register-file write port (`write_reg`, `write_data`, `regWrite`) of the MIPS core. It merges single-cycle ALU results with results from long-latency units (loads, multiply/divide) arriving over a valid/ready handshake. Long-latency results are buffered in a small in-order FIFO, and the arbiter tracks per-register pending writes for the hazard unit. ALU results always win the port; stale queued results are cancelled to preserve write-after-write order.

## Interface
- `DEPTH`, 4, FIFO entries for long-latency results; power of two, at least 2.
- `DATA_W`, 32, result data width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `alu_valid`  in  1  ALU result valid this cycle; no backpressure.
- `alu_reg`  in  5  ALU destination register.
- `alu_data`  in  DATA_W  ALU result.
- `lu_valid`  in  1  long-latency result valid.
- `lu_reg`  in  5  long-latency destination register.
- `lu_data`  in  DATA_W  long-latency result.
- `lu_ready`  out  1  arbiter accepts the long-latency result; a transfer occurs when `lu_valid & lu_ready`.
- `write_reg`  out  5  register-file write address (registered).
- `write_data`  out  DATA_W  register-file write data (registered).
- `regWrite`  out  1  register-file write enable (registered).
- `pending`  out  32  bit i is set while a live FIFO entry targets register i; bit 0 is always 0.
- `fifo_count`  out  log2(DEPTH)+1  number of FIFO entries, live or killed.
- `byp_reg`  in  5  bypass lookup register (present only with `WB_BYPASS_EN`).
- `byp_hit`  out  1  bypass hit (present only with `WB_BYPASS_EN`).
- `byp_data`  out  DATA_W  bypass data (present only with `WB_BYPASS_EN`).

## Operation
- **Output-stage selection, evaluated each cycle in priority order:**
  1. `alu_valid && alu_reg != 0` → load the ALU result with `regWrite=1`.
  2. FIFO non-empty → pop the head. If the head is live, `regWrite=1` with its reg/data. If it is killed, `regWrite=0` (the pop still consumes the cycle).
  3. FIFO empty and an LU transfer with `lu_reg != 0` → pass through directly with `regWrite=1`; nothing is pushed.
  4. Otherwise `regWrite=0`; `write_reg`/`write_data` hold their previous values.
- **LU push:** an LU transfer with `lu_reg != 0` not passed through in case 3 is pushed as a live entry.
  - An LU transfer with `lu_reg == 0` is accepted and discarded.
  - An ALU input with `alu_reg == 0` is ignored and does not claim the port.
- **`lu_ready`** = `rst_n && fifo_count < DEPTH`, based on the registered count. When the FIFO is full, `lu_ready` is 0 even if a pop occurs this cycle.
- **WAW kill:** an ALU write to register X clears the live bit of every FIFO entry targeting X. An LU result pushed in the same cycle for X is treated as younger and stays live.
- **`pending`:** OR of one-hot(reg) over live entries, after that cycle's kills, pushes and pops.
- Simultaneous push and pop when non-empty: `fifo_count` is unchanged and order is preserved.

## Timing
- Latency: 1 cycle from an accepted input to `regWrite` for the ALU path and for an LU result passed through an empty FIFO. Queued results add 1 cycle per older queued entry plus 1 cycle per competing ALU cycle.
- `pending`, `fifo_count` and `lu_ready` reflect registered state; the new value is visible the cycle after the edge.
- Reset (`rst_n=0` at an edge) gives: `regWrite=0`, `write_reg=0`, `write_data=0`, FIFO empty, `pending=0`, `fifo_count=0`. `lu_ready=0` while `rst_n` is low.
- Reset mid-operation discards all queued entries without writing them.
- The FIFO read/write pointers wrap modulo DEPTH; full/empty are distinguished by `fifo_count`.

## Configuration
- `WB_BYPASS_EN` defined: adds `byp_reg`, `byp_hit` and `byp_data`, all combinational.
  - Hit order: the youngest live FIFO entry matching `byp_reg`, else the output stage when `regWrite && write_reg == byp_reg`.
  - `byp_reg == 0` never hits.
- Undefined: the bypass ports and their search logic are absent.

## Test plan
- **Reset:** hold `rst_n=0` for 2 cycles with `lu_valid=1` → `lu_ready=0`, `regWrite=0`, `pending=0`. After release, `lu_ready=1`.
- **Pass-through:** empty FIFO, LU (r5, 0x11) transfers → next cycle `regWrite=1`, `write_reg=5`, `write_data=0x11`, `fifo_count=0`.
- **Contention:** ALU (r3, 0xA) and LU (r4, 0xB) in the same cycle → cycle+1 writes r3. `pending[4]=1` → cycle+2 writes r4 and `pending` clears.
- **Full FIFO:** hold `alu_valid` (r1) continuously and offer 5 LU results → exactly 4 are accepted and `lu_ready` drops at `fifo_count=4`. Releasing the ALU drains them in order, 1 per cycle.
- **WAW kill:** queue LU (r7, 0x70), then ALU (r7, 0x99) → r7 is written with 0x99. The queued entry pops with `regWrite=0` and `pending[7]` clears the cycle after the ALU write.
- **Register 0:** ALU (r0) and LU (r0) → never `regWrite=1`. The LU transfer completes and the FIFO is unchanged. With `WB_BYPASS_EN`, `byp_reg=0` gives `byp_hit=0`.
